seri_uart_cekirdek: RTL and testbench

//  Parametrised UART transceiver, successor to the fixed-rate 8N1 serial block.
//  TX takes bytes over a valid/ready handshake; RX oversamples the line and buffers

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_fifo.sv | 68 ++++++
 rtl/seri_uart_cekirdek.sv | 223 ++++++++++++++++++++++
 tb/tb_seri_uart_cekirdek.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: TX/RX state encodings and the FIFO pointer-width helper.
// UART_PARITE_EN adds the PARITE state to both FSMs.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_BOSTA  = 3'd0,
        TX_BASLA  = 3'd1,
        TX_VERI   = 3'd2,
`ifdef UART_PARITE_EN
        TX_PARITE = 3'd3,
`endif
        TX_DUR    = 3'd4
    } tx_durum_t;

    typedef enum logic [2:0] {
        RX_BOSTA  = 3'd0,
        RX_BASLA  = 3'd1,
        RX_VERI   = 3'd2,
`ifdef UART_PARITE_EN
        RX_PARITE = 3'd3,
`endif
        RX_DUR    = 3'd4,
        RX_BEKLE  = 3'd5
    } rx_durum_t;

    function automatic int isaretci_genislik(input int derinlik);
        return (derinlik > 1) ? $clog2(derinlik) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// RX word FIFO: storage, wrapping pointers, occupancy count and overflow pulse.
// Same behaviour with or without UART_PARITE_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int VERI_BIT      = 8,
    parameter int FIFO_DERINLIK = 16
) (
    input  logic                                i_saat,
    input  logic                                i_sifirla,
    input  logic                                i_yaz,
    input  logic [VERI_BIT-1:0]                 i_yaz_veri,
    input  logic                                i_oku,
    output logic [VERI_BIT-1:0]                 o_bas_veri,
    output logic                                o_gecerli,
    output logic [$clog2(FIFO_DERINLIK):0]      o_sayac,
    output logic                                o_tasma
);
    localparam int AW = isaretci_genislik(FIFO_DERINLIK);

    logic [VERI_BIT-1:0] r_bellek [FIFO_DERINLIK];
    logic [AW-1:0]       r_oku_ptr;
    logic [AW-1:0]       r_yaz_ptr;
    logic [AW:0]         r_sayac;
    logic                r_tasma;
    logic                w_bos;
    logic                w_dolu;
    logic                w_pop;
    logic                w_push;

    assign w_bos  = (r_sayac == '0);
    assign w_dolu = (r_sayac == (AW+1)'(FIFO_DERINLIK));
    assign w_pop  = i_oku && !w_bos;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push = i_yaz && (!w_dolu || w_pop);

    always_ff @(posedge i_saat) begin
        if (i_sifirla) begin
            r_oku_ptr <= '0;
            r_yaz_ptr <= '0;
            r_sayac   <= '0;
            r_tasma   <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DERINLIK; i++) begin
                r_bellek[i] <= '0;
            end
        end else begin
            r_tasma <= i_yaz && w_dolu && !w_pop;
            if (w_push) begin
                r_bellek[r_yaz_ptr] <= i_yaz_veri;
                r_yaz_ptr           <= r_yaz_ptr + 1'b1;
            end
            if (w_pop) begin
                r_oku_ptr <= r_oku_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_sayac <= r_sayac + 1'b1;
                2'b01:   r_sayac <= r_sayac - 1'b1;
                default: r_sayac <= r_sayac;
            endcase
        end
    end

    assign o_bas_veri = r_bellek[r_oku_ptr];
    assign o_gecerli  = !w_bos;
    assign o_sayac    = r_sayac;
    assign o_tasma    = r_tasma;

endmodule

// File: rtl/seri_uart_cekirdek.sv
// Parametrised UART transceiver: handshake TX, oversampled RX feeding a word FIFO.
// Define UART_PARITE_EN for an even-parity bit on both directions.
module seri_uart_cekirdek
    import uart_pkg::*;
#(
    parameter int BAUD_BOLME    = 326,
    parameter int ORNEKLEME     = 16,
    parameter int VERI_BIT      = 8,
    parameter int FIFO_DERINLIK = 16
) (
    input  logic                            saatDarbesi,
    input  logic                            sifirlama,
    input  logic                            gelenVeri,
    output logic                            gidenVeri,
    input  logic [VERI_BIT-1:0]             txVeri,
    input  logic                            txGecerli,
    output logic                            txHazir,
    output logic [VERI_BIT-1:0]             rxVeri,
    output logic                            rxGecerli,
    input  logic                            rxOku,
    output logic [$clog2(FIFO_DERINLIK):0]  rxSayac,
    output logic                            cerceveHata,
    output logic                            tasmaHata,
    output logic                            pariteHata
);
    localparam int BIT_SURE = BAUD_BOLME * ORNEKLEME;
    localparam int SW = $clog2(BIT_SURE);
    localparam int BW = $clog2(VERI_BIT);
    localparam int DW = (BAUD_BOLME > 1) ? $clog2(BAUD_BOLME) : 1;
    localparam int TW = $clog2(ORNEKLEME);

    tx_durum_t           r_tx_durum;
    logic [SW-1:0]       r_tx_sayac;
    logic [BW-1:0]       r_tx_bit;
    logic [VERI_BIT-1:0] r_tx_kaydirma;
    logic                r_tx_cikis;
    logic                w_tx_bit_son;
`ifdef UART_PARITE_EN
    logic                r_tx_parite;
`endif

    assign w_tx_bit_son = (r_tx_sayac == SW'(BIT_SURE - 1));

    always_ff @(posedge saatDarbesi) begin
        if (sifirlama) begin
            r_tx_durum    <= TX_BOSTA;
            r_tx_sayac    <= '0;
            r_tx_bit      <= '0;
            r_tx_kaydirma <= '0;
            r_tx_cikis    <= 1'b1;
`ifdef UART_PARITE_EN
            r_tx_parite   <= 1'b0;
`endif
        end else begin
            r_tx_sayac <= w_tx_bit_son ? '0 : r_tx_sayac + 1'b1;
            case (r_tx_durum)
                TX_BOSTA: begin
                    r_tx_sayac <= '0;
                    if (txGecerli) begin
                        r_tx_kaydirma <= txVeri;
                        r_tx_bit      <= '0;
                        r_tx_cikis    <= 1'b0;
                        r_tx_durum    <= TX_BASLA;
`ifdef UART_PARITE_EN
                        r_tx_parite   <= ^txVeri;
`endif
                    end
                end
                TX_BASLA: if (w_tx_bit_son) begin
                    r_tx_cikis <= r_tx_kaydirma[0];
                    r_tx_durum <= TX_VERI;
                end
                TX_VERI: if (w_tx_bit_son) begin
                    if (r_tx_bit == BW'(VERI_BIT - 1)) begin
`ifdef UART_PARITE_EN
                        r_tx_cikis <= r_tx_parite;
                        r_tx_durum <= TX_PARITE;
`else
                        r_tx_cikis <= 1'b1;
                        r_tx_durum <= TX_DUR;
`endif
                    end else begin
                        r_tx_bit      <= r_tx_bit + 1'b1;
                        r_tx_cikis    <= r_tx_kaydirma[1];
                        r_tx_kaydirma <= r_tx_kaydirma >> 1;
                    end
                end
`ifdef UART_PARITE_EN
                TX_PARITE: if (w_tx_bit_son) begin
                    r_tx_cikis <= 1'b1;
                    r_tx_durum <= TX_DUR;
                end
`endif
                TX_DUR: if (w_tx_bit_son) r_tx_durum <= TX_BOSTA;
                default: r_tx_durum <= TX_BOSTA;
            endcase
        end
    end

    assign gidenVeri = r_tx_cikis;
    assign txHazir   = (r_tx_durum == TX_BOSTA);

    rx_durum_t           r_rx_durum;
    logic                r_senk1;
    logic                r_senk2;
    logic [DW-1:0]       r_rx_bolme;
    logic [TW-1:0]       r_rx_tik;
    logic [BW-1:0]       r_rx_bit;
    logic [VERI_BIT-1:0] r_rx_kaydirma;
    logic                r_cerceve_hata;
    logic                w_tik;
    logic                w_ornek;
    logic                w_parite_tamam;
    logic                w_yaz;
`ifdef UART_PARITE_EN
    logic                r_rx_parite;
    logic                r_parite_hata;
    assign w_parite_tamam = ~^{r_rx_kaydirma, r_rx_parite};
`else
    assign w_parite_tamam = 1'b1;
`endif

    assign w_tik   = (r_rx_bolme == DW'(BAUD_BOLME - 1));
    // Mid-bit sampling point: ORNEKLEME ticks after the previous sample.
    assign w_ornek = w_tik && (r_rx_tik == TW'(ORNEKLEME - 1));
    assign w_yaz   = (r_rx_durum == RX_DUR) && w_ornek && r_senk2 && w_parite_tamam;

    always_ff @(posedge saatDarbesi) begin
        if (sifirlama) begin
            r_senk1        <= 1'b1;
            r_senk2        <= 1'b1;
            r_rx_bolme     <= '0;
            r_rx_durum     <= RX_BOSTA;
            r_rx_tik       <= '0;
            r_rx_bit       <= '0;
            r_rx_kaydirma  <= '0;
            r_cerceve_hata <= 1'b0;
`ifdef UART_PARITE_EN
            r_rx_parite    <= 1'b0;
            r_parite_hata  <= 1'b0;
`endif
        end else begin
            r_senk1        <= gelenVeri;
            r_senk2        <= r_senk1;
            r_rx_bolme     <= w_tik ? '0 : r_rx_bolme + 1'b1;
            r_cerceve_hata <= 1'b0;
`ifdef UART_PARITE_EN
            r_parite_hata  <= 1'b0;
`endif
            if (w_tik) begin
                r_rx_tik <= (r_rx_tik == TW'(ORNEKLEME - 1)) ? '0 : r_rx_tik + 1'b1;
                case (r_rx_durum)
                    RX_BOSTA: begin
                        r_rx_tik <= '0;
                        if (!r_senk2) r_rx_durum <= RX_BASLA;
                    end
                    RX_BASLA: if (r_rx_tik == TW'(ORNEKLEME / 2 - 1)) begin
                        r_rx_tik   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_durum <= r_senk2 ? RX_BOSTA : RX_VERI;
                    end
                    RX_VERI: if (w_ornek) begin
                        r_rx_kaydirma <= {r_senk2, r_rx_kaydirma[VERI_BIT-1:1]};
                        if (r_rx_bit == BW'(VERI_BIT - 1)) begin
`ifdef UART_PARITE_EN
                            r_rx_durum <= RX_PARITE;
`else
                            r_rx_durum <= RX_DUR;
`endif
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end
`ifdef UART_PARITE_EN
                    RX_PARITE: if (w_ornek) begin
                        r_rx_parite <= r_senk2;
                        r_rx_durum  <= RX_DUR;
                    end
`endif
                    RX_DUR: if (w_ornek) begin
`ifdef UART_PARITE_EN
                        r_parite_hata <= !w_parite_tamam;
`endif
                        if (r_senk2) begin
                            r_rx_durum <= RX_BOSTA;
                        end else begin
                            r_cerceve_hata <= 1'b1;
                            r_rx_durum     <= RX_BEKLE;
                        end
                    end
                    RX_BEKLE: begin
                        r_rx_tik <= '0;
                        if (r_senk2) r_rx_durum <= RX_BOSTA;
                    end
                    default: r_rx_durum <= RX_BOSTA;
                endcase
            end
        end
    end

    assign cerceveHata = r_cerceve_hata;
`ifdef UART_PARITE_EN
    assign pariteHata  = r_parite_hata;
`else
    assign pariteHata  = 1'b0;
`endif

    uart_rx_fifo #(
        .VERI_BIT      (VERI_BIT),
        .FIFO_DERINLIK (FIFO_DERINLIK)
    ) u_rx_fifo (
        .i_saat     (saatDarbesi),
        .i_sifirla  (sifirlama),
        .i_yaz      (w_yaz),
        .i_yaz_veri (r_rx_kaydirma),
        .i_oku      (rxOku),
        .o_bas_veri (rxVeri),
        .o_gecerli  (rxGecerli),
        .o_sayac    (rxSayac),
        .o_tasma    (tasmaHata)
    );

endmodule

// File: tb/tb_seri_uart_cekirdek.sv
// Self-checking bench for seri_uart_cekirdek: TX waveform, loopback, RX error paths.
// Honours UART_PARITE_EN for frame length and the parity-error case.
module tb_seri_uart_cekirdek;
    localparam int BAUD = 4;
    localparam int ORN  = 16;
    localparam int VB   = 8;
    localparam int DER  = 4;
    localparam int BIT  = BAUD * ORN;
`ifdef UART_PARITE_EN
    localparam int CERCEVE = VB + 3;
`else
    localparam int CERCEVE = VB + 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          gelen;
    logic          giden;
    logic [VB-1:0] txVeri;
    logic          txGecerli;
    logic          txHazir;
    logic [VB-1:0] rxVeri;
    logic          rxGecerli;
    logic          rxOku;
    logic [2:0]    rxSayac;
    logic          cerceveHata;
    logic          tasmaHata;
    logic          pariteHata;

    logic          r_dongu;
    logic          r_hat;
    assign gelen = r_dongu ? giden : r_hat;

    seri_uart_cekirdek #(
        .BAUD_BOLME    (BAUD),
        .ORNEKLEME     (ORN),
        .VERI_BIT      (VB),
        .FIFO_DERINLIK (DER)
    ) dut (
        .saatDarbesi (clk),
        .sifirlama   (rst),
        .gelenVeri   (gelen),
        .gidenVeri   (giden),
        .txVeri      (txVeri),
        .txGecerli   (txGecerli),
        .txHazir     (txHazir),
        .rxVeri      (rxVeri),
        .rxGecerli   (rxGecerli),
        .rxOku       (rxOku),
        .rxSayac     (rxSayac),
        .cerceveHata (cerceveHata),
        .tasmaHata   (tasmaHata),
        .pariteHata  (pariteHata)
    );

    always #5 clk = ~clk;

    int n_test = 0;
    int n_hata = 0;
    int n_cerceve = 0;
    int n_tasma = 0;
    int n_parite = 0;
    int beklenen_tasma = 0;
    int cyc = 0;
    int son_artis = 0;
    logic [2:0] onceki_sayac = '0;
    logic [VB-1:0] q[$];

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (cerceveHata) n_cerceve++;
        if (tasmaHata)   n_tasma++;
        if (pariteHata)  n_parite++;
        if (rxSayac > onceki_sayac) son_artis = cyc;
        onceki_sayac = rxSayac;
    end

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        n_test++;
        if (gozlenen !== beklenen) begin
            n_hata++;
            $display("FAIL %s: gozlenen=%0h beklenen=%0h", etiket, gozlenen, beklenen);
        end
    endtask

    function automatic void model_yaz(input logic [VB-1:0] d);
        if (q.size() < DER) q.push_back(d);
        else beklenen_tasma++;
    endfunction

    // Expected line level per bit slot of one frame.
    function automatic logic [CERCEVE-1:0] cerceve_bitleri(input logic [VB-1:0] d);
        logic [CERCEVE-1:0] b;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < VB; i++) b[i+1] = d[i];
`ifdef UART_PARITE_EN
        b[VB+1] = ^d;
`endif
        return b;
    endfunction

    task automatic tx_gonder(input logic [VB-1:0] d);
        int bekle;
        bekle = 0;
        @(negedge clk);
        while (!txHazir && bekle < 3000) begin
            @(negedge clk);
            bekle++;
        end
        if (bekle >= 3000) kontrol("tx_hazir_zaman_asimi", 32'(txHazir), 32'd1);
        txVeri = d;
        txGecerli = 1'b1;
        @(negedge clk);
        txGecerli = 1'b0;
        if (r_dongu) model_yaz(d);
    endtask

    task automatic tx_bitir();
        int bekle;
        bekle = 0;
        while (!txHazir && bekle < 3000) begin
            @(negedge clk);
            bekle++;
        end
        if (bekle >= 3000) kontrol("tx_bitir_zaman_asimi", 32'(txHazir), 32'd1);
        repeat (BIT) @(negedge clk);
    endtask

    task automatic bb_gonder(input logic [VB-1:0] d, input logic boz, input logic dur);
        r_hat = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < VB; i++) begin
            r_hat = d[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_PARITE_EN
        r_hat = (^d) ^ boz;
        repeat (BIT) @(negedge clk);
`else
        if (boz) r_hat = 1'b1;
`endif
        r_hat = dur;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic pop_kontrol(input string etiket);
        logic [VB-1:0] b;
        b = (q.size() > 0) ? q.pop_front() : '0;
        kontrol({etiket, "_gecerli"}, 32'(rxGecerli), 32'd1);
        kontrol(etiket, 32'(rxVeri), 32'(b));
        rxOku = 1'b1;
        @(negedge clk);
        rxOku = 1'b0;
    endtask

    task automatic faz_hizala();
        @(negedge clk);
        for (int i = 0; i < 4 && (cyc % 4) != 0; i++) @(negedge clk);
    endtask

    initial begin
        logic [CERCEVE-1:0] bitler;
        logic [VB-1:0] merh[4];
        logic [VB-1:0] w[6];
        logic [VB-1:0] d;
        int sapma, n, c0, t0, p0, s, dgec;

        merh = '{8'h4D, 8'h65, 8'h72, 8'h68};
        rst = 1'b1; txGecerli = 1'b0; txVeri = '0; rxOku = 1'b0; r_dongu = 1'b0; r_hat = 1'b1;
        repeat (3) @(negedge clk);
        kontrol("rst_giden", 32'(giden), 32'd1);
        kontrol("rst_txhazir", 32'(txHazir), 32'd1);
        kontrol("rst_rxgecerli", 32'(rxGecerli), 32'd0);
        kontrol("rst_rxsayac", 32'(rxSayac), 32'd0);
        kontrol("rst_rxveri", 32'(rxVeri), 32'd0);
        kontrol("rst_hatalar", 32'({cerceveHata, tasmaHata, pariteHata}), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // TX waveform of 'M', looped back into RX
        r_dongu = 1'b1;
        bitler = cerceve_bitleri(8'h4D);
        tx_gonder(8'h4D);
        for (int i = 0; i < CERCEVE; i++) begin
            sapma = 0;
            for (int c = 0; c < BIT; c++) begin
                if (i == 0 && c == 0) kontrol("tx_hazir_dustu", 32'(txHazir), 32'd0);
                if (i == CERCEVE - 1 && c == BIT - 1) kontrol("tx_hazir_erken", 32'(txHazir), 32'd0);
                if (giden !== bitler[i]) sapma++;
                @(negedge clk);
            end
            kontrol($sformatf("tx_bit%0d", i), 32'(sapma), 32'd0);
        end
        kontrol("tx_hazir_geri", 32'(txHazir), 32'd1);
        repeat (BIT) @(negedge clk);
        kontrol("rx_M_sayac", 32'(rxSayac), 32'(q.size()));
        pop_kontrol("rx_M");

        // "Merh" loopback, back-to-back
        foreach (merh[i]) tx_gonder(merh[i]);
        tx_bitir();
        kontrol("merh_sayac", 32'(rxSayac), 32'(q.size()));
        for (int i = 0; i < 4; i++) pop_kontrol("merh_pop");
        kontrol("merh_bos", 32'(rxGecerli), 32'd0);

        // Random loopback batches
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) tx_gonder(VB'($urandom));
            tx_bitir();
            kontrol("rast_sayac", 32'(rxSayac), 32'(q.size()));
            while (q.size() > 0) pop_kontrol("rast_pop");
        end

        // Short low glitch on the line
        r_dongu = 1'b0; r_hat = 1'b1;
        repeat (BIT) @(negedge clk);
        c0 = n_cerceve; t0 = n_tasma; p0 = n_parite;
        r_hat = 1'b0;
        repeat (20) @(negedge clk);
        r_hat = 1'b1;
        repeat (4 * BIT) @(negedge clk);
        kontrol("glitch_sayac", 32'(rxSayac), 32'd0);
        kontrol("glitch_hata", 32'((n_cerceve - c0) + (n_tasma - t0) + (n_parite - p0)), 32'd0);

        // Framing error followed by a break, then a valid word
        c0 = n_cerceve;
        bb_gonder(8'h55, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        kontrol("cerceve_darbe", 32'(n_cerceve - c0), 32'd1);
        kontrol("cerceve_sayac", 32'(rxSayac), 32'd0);
        r_hat = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        bb_gonder(8'h41, 1'b0, 1'b1);
        q.push_back(8'h41);
        repeat (BIT) @(negedge clk);
        kontrol("kirilma_sonrasi_sayac", 32'(rxSayac), 32'(q.size()));
        pop_kontrol("kirilma_sonrasi");
        kontrol("cerceve_tek", 32'(n_cerceve - c0), 32'd1);

        // Overflow and simultaneous push+pop while full
        foreach (w[i]) w[i] = VB'($urandom);
        beklenen_tasma = n_tasma;
        for (int k = 0; k < 3; k++) begin
            bb_gonder(w[k], 1'b0, 1'b1);
            model_yaz(w[k]);
            repeat (BIT / 2) @(negedge clk);
        end
        faz_hizala();
        s = cyc;
        bb_gonder(w[3], 1'b0, 1'b1);
        model_yaz(w[3]);
        repeat (BIT / 2) @(negedge clk);
        dgec = son_artis - s;
        kontrol("dolu_sayac", 32'(rxSayac), 32'(q.size()));
        bb_gonder(w[4], 1'b0, 1'b1);
        model_yaz(w[4]);
        repeat (BIT / 2) @(negedge clk);
        kontrol("tasma_darbe", 32'(n_tasma), 32'(beklenen_tasma));
        kontrol("tasma_sayac", 32'(rxSayac), 32'(q.size()));
        faz_hizala();
        s = cyc;
        fork
            bb_gonder(w[5], 1'b0, 1'b1);
            begin
                for (int g = 0; g < 2000 && cyc != s + dgec - 1; g++) @(negedge clk);
                pop_kontrol("eszaman_bas");
            end
        join
        model_yaz(w[5]);
        repeat (BIT / 2) @(negedge clk);
        kontrol("eszaman_sayac", 32'(rxSayac), 32'(q.size()));
        kontrol("eszaman_tasma", 32'(n_tasma), 32'(beklenen_tasma));
        while (q.size() > 0) pop_kontrol("tasma_bosalt");

        // Reset in the middle of a TX frame
        r_dongu = 1'b1;
        tx_gonder(VB'($urandom));
        tx_bitir();
        kontrol("rst_oncesi_sayac", 32'(rxSayac), 32'(q.size()));
        r_dongu = 1'b0; r_hat = 1'b1;
        d = VB'($urandom);
        tx_gonder(d);
        repeat (4 * BIT + 20) @(negedge clk);
        kontrol("tx_veri_bit3", 32'(giden), 32'(d[3]));
        rst = 1'b1;
        @(negedge clk);
        q.delete();
        kontrol("ortarst_giden", 32'(giden), 32'd1);
        kontrol("ortarst_txhazir", 32'(txHazir), 32'd1);
        kontrol("ortarst_rxsayac", 32'(rxSayac), 32'd0);
        kontrol("ortarst_rxgecerli", 32'(rxGecerli), 32'd0);
        rst = 1'b0;
        repeat (2 * BIT) @(negedge clk);

`ifdef UART_PARITE_EN
        p0 = n_parite;
        bb_gonder(8'h3C, 1'b1, 1'b1);
        repeat (BIT) @(negedge clk);
        kontrol("parite_darbe", 32'(n_parite - p0), 32'd1);
        kontrol("parite_sayac", 32'(rxSayac), 32'd0);
        bb_gonder(8'h3C, 1'b0, 1'b1);
        q.push_back(8'h3C);
        repeat (BIT) @(negedge clk);
        pop_kontrol("parite_dogru");
`endif

        $display("[TB] %0d tests run, %0d failed", n_test, n_hata);
        $finish;
    end

    initial begin
        #5_000_000;
        n_hata++;
        $display("FAIL watchdog: gozlenen=zaman_asimi beklenen=bitis");
        $display("[TB] %0d tests run, %0d failed", n_test, n_hata);
        $fatal(1, "watchdog");
    end

endmodule
